// File: rtl/bus_pkg.sv
// Shared definitions for the one-hot bus system: widths, sequencer states,
// the queued request record and the one-hot decode used to drive selects.
package bus_pkg;

  localparam int NUM_BUS_SOURCES = 24;
  localparam int BUS_IDX_W       = 5;
  localparam int BUS_CTRL_W      = 32;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    LOAD
  } seq_state_t;

  typedef struct packed {
    logic [BUS_IDX_W-1:0] src;
    logic [BUS_IDX_W-1:0] dst;
  } xfer_req_t;

  function automatic logic [BUS_CTRL_W-1:0] one_hot(input logic [BUS_IDX_W-1:0] idx);
    return BUS_CTRL_W'(1) << idx;
  endfunction

endpackage

// File: rtl/seq_req_fifo.sv
// Small synchronous FIFO holding pending {src,dst} transfer requests.
// The head entry is visible combinationally on rd_data whenever not empty.
module seq_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wr_data,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + (PTR_W+1)'(1);
      else if (pop && !push) count <= count - (PTR_W+1)'(1);
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Drives the bus encoder select and destination load enable for queued
// register transfers: select the source, let the bus settle, then load.
module bus_transfer_sequencer
  import bus_pkg::*;
#(
  parameter int NUM_SRC       = NUM_BUS_SOURCES,
  parameter int NUM_DST       = 24,
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [BUS_IDX_W-1:0]  req_src,
  input  logic [BUS_IDX_W-1:0]  req_dst,
  output logic [BUS_CTRL_W-1:0] bus_sel,
  output logic [BUS_CTRL_W-1:0] ld_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0]     SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [BUS_IDX_W:0]   SRC_LIM     = (BUS_IDX_W+1)'(NUM_SRC);
  localparam logic [BUS_IDX_W:0]   DST_LIM     = (BUS_IDX_W+1)'(NUM_DST);

  seq_state_t           state;
  logic [SET_W-1:0]     settle_cnt;
  logic [BUS_IDX_W-1:0] dst_q;

  logic       accept;
  logic       req_ok;
  logic       push;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  xfer_req_t  new_req;
  xfer_req_t  head;

  assign accept  = req_valid && req_ready;
  assign req_ok  = ({1'b0, req_src} < SRC_LIM) && ({1'b0, req_dst} < DST_LIM);
  assign push    = accept && req_ok;
  assign new_req = '{src: req_src, dst: req_dst};

  // Pop only where the FSM can immediately start the next transfer.
  assign pop = !fifo_empty && ((state == IDLE) || (state == LOAD));

  seq_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(xfer_req_t))
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wr_data (new_req),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign req_ready = !fifo_full;
  assign busy      = (state != IDLE) || (fifo_count != '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      dst_q      <= '0;
      bus_sel    <= '0;
      ld_en      <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      err   <= accept && !req_ok;
      ld_en <= '0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            bus_sel    <= one_hot(head.src);
            dst_q      <= head.dst;
            settle_cnt <= '0;
            state      <= DRIVE;
          end
        end
        DRIVE: begin
          if (settle_cnt == SETTLE_LAST) begin
            ld_en <= one_hot(dst_q);
            done  <= 1'b1;
            state <= LOAD;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end
        LOAD: begin
          // Chain straight into the next transfer so there is no idle bubble.
          if (pop) begin
            bus_sel    <= one_hot(head.src);
            dst_q      <= head.dst;
            settle_cnt <= '0;
            state      <= DRIVE;
          end else begin
            bus_sel <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Scoreboard bench: stimulus predicts each transfer's timing into a queue,
// per-cycle monitors compare the DUT outputs against the predicted window.
module tb_bus_transfer_sequencer;

  localparam int S1    = 1;
  localparam int S3    = 3;
  localparam int DEPTH = 4;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b1;

  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_src;
  logic [4:0]  req_dst;
  logic [31:0] bus_sel;
  logic [31:0] ld_en;
  logic        busy;
  logic        done;
  logic        err;

  logic        valid3;
  logic        ready3;
  logic [4:0]  src3;
  logic [4:0]  dst3;
  logic [31:0] bus_sel3;
  logic [31:0] ld_en3;
  logic        busy3;
  logic        done3;
  logic        err3;

  typedef struct {
    int src;
    int dst;
    int a;
    int d;
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t exp3_q[$];
  int    err_q[$];
  int    last_d = 0;
  int    cyc    = 0;
  int    checks = 0;
  int    errors = 0;

  bus_transfer_sequencer #(
    .NUM_SRC(24), .NUM_DST(24), .FIFO_DEPTH(DEPTH), .SETTLE_CYCLES(S1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst), .bus_sel(bus_sel), .ld_en(ld_en),
    .busy(busy), .done(done), .err(err)
  );

  bus_transfer_sequencer #(
    .NUM_SRC(24), .NUM_DST(24), .FIFO_DEPTH(DEPTH), .SETTLE_CYCLES(S3)
  ) dut3 (
    .clock(clock), .reset_n(reset_n), .req_valid(valid3), .req_ready(ready3),
    .req_src(src3), .req_dst(dst3), .bus_sel(bus_sel3), .ld_en(ld_en3),
    .busy(busy3), .done(done3), .err(err3)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  // Leaves req_valid high so consecutive calls form a continuous stream.
  task automatic applyStimulus(input int src, input int dst);
    int    waited;
    xfer_t t;
    waited    = 0;
    req_valid = 1'b1;
    req_src   = src[4:0];
    req_dst   = dst[4:0];
    while (!req_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout src=%0d dst=%0d: got req_ready=0 expected 1", src, dst);
    end else begin
      t.src = src;
      t.dst = dst;
      t.a   = cyc + 1;
      if (src >= 24 || dst >= 24) begin
        err_q.push_back(t.a);
      end else begin
        t.d    = ((t.a > last_d) ? t.a : last_d) + S1 + 1;
        last_d = t.d;
        exp_q.push_back(t);
      end
    end
    @(negedge clock);
  endtask

  task automatic drain();
    int waited;
    waited    = 0;
    req_valid = 1'b0;
    while ((exp_q.size() > 0 || err_q.size() > 0) && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    checkOutput("drain_pending", 32'(exp_q.size() + err_q.size()), 32'd0);
    @(negedge clock);
  endtask

  always @(negedge clock) begin
    logic [31:0] exp_bus;
    logic [31:0] exp_ld;
    logic        exp_busy;
    logic        exp_err;
    int          in_fifo;
    if (reset_n) begin
      exp_bus  = '0;
      exp_ld   = '0;
      exp_busy = 1'b0;
      in_fifo  = 0;
      if (exp_q.size() > 0) begin
        if (cyc >= exp_q[0].d - S1 && cyc <= exp_q[0].d) exp_bus = 32'h1 << exp_q[0].src;
        if (cyc == exp_q[0].d) exp_ld = 32'h1 << exp_q[0].dst;
        if (cyc >= exp_q[0].a) exp_busy = 1'b1;
      end
      foreach (exp_q[i]) begin
        if (exp_q[i].a <= cyc && cyc < exp_q[i].d - S1) in_fifo++;
      end
      exp_err = (err_q.size() > 0) && (err_q[0] == cyc);
      checkOutput("bus_sel", bus_sel, exp_bus);
      checkOutput("ld_en", ld_en, exp_ld);
      checkOutput("done", 32'(done), 32'(exp_ld != 0));
      checkOutput("busy", 32'(busy), 32'(exp_busy));
      checkOutput("req_ready", 32'(req_ready), 32'(in_fifo < DEPTH));
      checkOutput("err", 32'(err), 32'(exp_err));
      if (err_q.size() > 0 && err_q[0] <= cyc) void'(err_q.pop_front());
      if (exp_q.size() > 0 && exp_q[0].d <= cyc) void'(exp_q.pop_front());
    end
  end

  always @(negedge clock) begin
    logic [31:0] exp_bus;
    logic [31:0] exp_ld;
    if (reset_n) begin
      exp_bus = '0;
      exp_ld  = '0;
      if (exp3_q.size() > 0) begin
        if (cyc >= exp3_q[0].d - S3 && cyc <= exp3_q[0].d) exp_bus = 32'h1 << exp3_q[0].src;
        if (cyc == exp3_q[0].d) exp_ld = 32'h1 << exp3_q[0].dst;
      end
      checkOutput("s3_bus_sel", bus_sel3, exp_bus);
      checkOutput("s3_ld_en", ld_en3, exp_ld);
      checkOutput("s3_done", 32'(done3), 32'(exp_ld != 0));
      if (exp3_q.size() > 0 && exp3_q[0].d <= cyc) void'(exp3_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    xfer_t t3;
    req_valid = 1'b0;
    req_src   = '0;
    req_dst   = '0;
    valid3    = 1'b0;
    src3      = '0;
    dst3      = '0;

    #1 reset_n = 1'b0;
    #1;
    checkOutput("rst_bus_sel", bus_sel, 32'h0);
    checkOutput("rst_ld_en", ld_en, 32'h0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    $display("[TB] single transfer src=5 dst=12");
    applyStimulus(5, 12);
    drain();

    $display("[TB] invalid source rejected");
    applyStimulus(24, 3);
    drain();

    $display("[TB] six back-to-back transfers");
    for (int i = 0; i < 6; i++) applyStimulus(i, 23 - i);
    drain();

    $display("[TB] self reload src=7 dst=7");
    applyStimulus(7, 7);
    drain();

    $display("[TB] reset during DRIVE with two queued");
    applyStimulus(2, 2);
    applyStimulus(3, 9);
    applyStimulus(1, 2);
    applyStimulus(4, 5);
    req_valid = 1'b0;
    reset_n   = 1'b0;
    exp_q.delete();
    err_q.delete();
    last_d = 0;
    #1;
    checkOutput("abort_bus_sel", bus_sel, 32'h0);
    checkOutput("abort_ld_en", ld_en, 32'h0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_req_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);

    $display("[TB] settle of 3 cycles src=0 dst=23");
    valid3 = 1'b1;
    src3   = 5'd0;
    dst3   = 5'd23;
    checkOutput("s3_req_ready", 32'(ready3), 32'd1);
    t3.src = 0;
    t3.dst = 23;
    t3.a   = cyc + 1;
    t3.d   = t3.a + S3 + 1;
    exp3_q.push_back(t3);
    @(negedge clock);
    valid3 = 1'b0;
    repeat (8) @(negedge clock);
    checkOutput("s3_drain", 32'(exp3_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
